io_frc_mc: RTL and testbench
============================

# io_frc_mc

Multi-channel free-run timer on the IO bus, the next-generation system timer. One parametrised-width counter with a programmable prescaler drives NCH independent compare channels. Each channel runs in one-shot or periodic (auto-reload) mode. Per-channel status is write-1-to-clear, and the counter overflow is also reported. A single masked interrupt line goes to the CSR/exception unit. Reads of the 64-bit counter are atomic. The block sits in the IO read-data daisy chain: it passes `dma_io_rdata_in` through when not selected.

## Interface
- CNT_W, 40: counter and compare width, 33..64.
- NCH, 4: number of compare channels, 1..8.
- PRE_W, 8: prescaler width.
- BASE_ADR, 14'h3E00: word address of offset 0; the window spans 8+4*NCH words.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- dma_io_we  in  1  bus write strobe
- dma_io_wadr  in  [15:2]  write word address
- dma_io_wdata  in  32  write data
- dma_io_radr  in  [15:2]  read word address
- dma_io_radr_en  in  1  read strobe
- dma_io_rdata_in  in  32  upstream read data
- dma_io_rdata  out  32  read data, pass-through when not selected
- csr_mtie  in  1  timer interrupt enable from the CSR unit
- frc_irq  out  1  registered interrupt request; reset 0

## Operation
- Register map, word offsets from BASE_ADR:
  - 0 VALLO
  - 1 VALHI (bits CNT_W-33:0)
  - 2 CNTRL: [0] run, [1] clear (write-only, reads 0), [15:8] prescale
  - 3 INTST: [NCH-1:0] channel match, [NCH] overflow; W1C
  - 4 INTEN: same bit layout as INTST
  - 5..7: reserved, read 0
  - channel n at 8+4n: +0 CMPLO, +1 CMPHI, +2 CHCTL ([0] en, [1] periodic), +3 PERIOD (32-bit, zero-extended to CNT_W)
- Unmapped addresses outside the window: not decoded, so rdata passes through.
- Tick: when run=1, the prescaler counts 0..prescale and emits one tick per (prescale+1) cycles; prescale=0 gives a tick every cycle. The prescaler counter resets to 0 when run=0 or on clear.
- Counter: increments on each tick and wraps modulo 2^CNT_W. On a wrap tick (all-ones to 0), INTST[NCH] is set.
- Counter priority: clear > VALLO commit > tick increment.
- Atomic access:
  - Reading VALLO latches the counter's upper bits into rd_shadow. Reading VALHI returns rd_shadow.
  - Writing VALHI loads wr_shadow only. Writing VALLO commits {wr_shadow, wdata} to the counter.
  - CMPLO/CMPHI use the same scheme with a per-channel write shadow.
- Match: a channel with en=1 fires when a tick occurs while cnt==cmp. Firing sets INTST[n]. Then:
  - periodic=1: cmp <= cmp + PERIOD, modulo 2^CNT_W.
  - periodic=0: en is cleared.
- Channel priority: a bus write to CMPLO/CHCTL wins over a reload or auto-disable in the same cycle.
- Status priority: when a set event and a W1C hit the same bit in the same cycle, the set wins.
- frc_irq <= csr_mtie & |(INTST & INTEN).

## Timing
- Reset: all registers and shadows are 0; counter stopped; frc_irq=0; all channels disabled.
- Writes take effect the cycle after dma_io_we. The register value is visible on the following clock edge.
- Read latency is 1 cycle: decode is registered, and data is muxed combinationally from current state in the cycle after dma_io_radr_en.
- INTST is set on the clock edge after the match tick. frc_irq follows 1 cycle later (2-cycle match-to-irq).
- A clear write resets the counter on the next edge. A tick in that same cycle is discarded.
- Asynchronous reset mid-count or mid-shadow sequence discards all state. No partial commit is allowed.

## Structure
- Package io_frc_mc_pkg holds:
  - register offset localparams
  - CNTRL/CHCTL bit positions
  - a function for the channel offset computation
- Sub-module io_frc_mc_ch, instantiated once per channel via generate, owns:
  - compare register, write shadow, period, and CHCTL
  - the match/reload logic
- Each instance receives cnt, tick, and its decoded write strobes, and outputs a match pulse plus read data.

## Test plan
- prescale=3, run=1 from 0: after 40 cycles VALLO reads 10. A VALLO write of 0x100 commits 0x100.
- Ch0 CMP=5, en=1, one-shot, INTEN[0]=1, csr_mtie=1:
  - INTST[0] sets after the tick at cnt 5; frc_irq rises 1 cycle later.
  - CHCTL.en reads 0.
  - W1C of INTST clears frc_irq.
- Ch1 periodic, CMP=10, PERIOD=10: matches at cnt 10, 20, 30; CMP reads 40. A W1C issued in the same cycle as the cnt-20 match leaves INTST[1]=1.
- Counter written to 2^CNT_W-2 via VALHI then VALLO: the wrap sets INTST[NCH] and the counter reads 0; a periodic reload across the wrap also wraps.
- Atomic read: read VALLO while the counter is at 0x00_FFFFFFFF and running; a later VALHI read returns 0x00 even though the counter has carried.
- Read of an address outside the window: dma_io_rdata equals dma_io_rdata_in. Clear and VALLO write in the same cycle: the counter reads 0.

Source files
------------

// File: rtl/io_frc_mc_pkg.sv
// io_frc_mc_pkg: register map, control bit positions and channel offset helper for io_frc_mc.
package io_frc_mc_pkg;
  localparam logic [13:0] OFF_VALLO = 14'd0;
  localparam logic [13:0] OFF_VALHI = 14'd1;
  localparam logic [13:0] OFF_CNTRL = 14'd2;
  localparam logic [13:0] OFF_INTST = 14'd3;
  localparam logic [13:0] OFF_INTEN = 14'd4;
  localparam logic [13:0] OFF_CH0   = 14'd8;
  localparam int CNTRL_RUN = 0;
  localparam int CNTRL_CLR = 1;
  localparam int CNTRL_PRE = 8;
  localparam int CHCTL_EN  = 0;
  localparam int CHCTL_PER = 1;
  typedef enum logic [1:0] {CH_CMPLO, CH_CMPHI, CH_CHCTL, CH_PERIOD} ch_reg_e;
  function automatic logic [13:0] ch_off(input int n);
    return OFF_CH0 + 14'(4 * n);
  endfunction
endpackage

// File: rtl/io_frc_mc_ch.sv
// io_frc_mc_ch: one compare channel with write shadow, one-shot/periodic reload and readback.
module io_frc_mc_ch
  import io_frc_mc_pkg::*;
#(
  parameter int CNT_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [1:0]       wsub_i,
  input  logic [31:0]      wdata_i,
  input  logic [1:0]       rsub_i,
  output logic             match_o,
  output logic [31:0]      rdata_o
);
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [CNT_W-33:0] wsh_q, wsh_d;
  logic [31:0]       per_q, per_d;
  logic              en_q, en_d, prd_q, prd_d;
  always_comb begin
    match_o = en_q & tick_i & (cnt_i == cmp_q);
    wsh_d   = (we_i && wsub_i == CH_CMPHI) ? wdata_i[CNT_W-33:0] : wsh_q;
    per_d   = (we_i && wsub_i == CH_PERIOD) ? wdata_i : per_q;
    prd_d   = (we_i && wsub_i == CH_CHCTL) ? wdata_i[CHCTL_PER] : prd_q;
    // bus writes take precedence over the reload/auto-disable of a same-cycle match
    cmp_d   = (we_i && wsub_i == CH_CMPLO) ? {wsh_q, wdata_i} :
              (match_o && prd_q) ? cmp_q + {{(CNT_W-32){1'b0}}, per_q} : cmp_q;
    en_d    = (we_i && wsub_i == CH_CHCTL) ? wdata_i[CHCTL_EN] :
              (match_o && !prd_q) ? 1'b0 : en_q;
    rdata_o = rsub_i == CH_CMPLO ? cmp_q[31:0] :
              rsub_i == CH_CMPHI ? 32'(cmp_q[CNT_W-1:32]) :
              rsub_i == CH_CHCTL ? {30'b0, prd_q, en_q} : per_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= '0;
      wsh_q <= '0;
      per_q <= '0;
      en_q  <= 1'b0;
      prd_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      wsh_q <= wsh_d;
      per_q <= per_d;
      en_q  <= en_d;
      prd_q <= prd_d;
    end
  end
endmodule

// File: rtl/io_frc_mc.sv
// io_frc_mc: multi-channel free-run timer on the IO bus with atomic 64-bit access and masked interrupt.
module io_frc_mc
  import io_frc_mc_pkg::*;
#(
  parameter int          CNT_W    = 40,
  parameter int          NCH      = 4,
  parameter int          PRE_W    = 8,
  parameter logic [13:0] BASE_ADR = 14'h3E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic        csr_mtie,
  output logic        frc_irq
);
  localparam logic [13:0] WIN = 14'(8 + 4 * NCH);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pcnt_q, pcnt_d, pre_q, pre_d;
  logic [CNT_W-33:0] wsh_q, wsh_d, rsh_q, rsh_d;
  logic [NCH:0]      intst_q, intst_d, inten_q, inten_d;
  logic              run_q, run_d, irq_q, irq_d, rd_sel_q, rd_sel_d;
  logic [13:0]       rd_off_q, woff, roff;
  logic              wr_hit, we_vallo, we_valhi, we_cntrl, we_intst, we_inten, clr, tick, cnt_tick;
  logic [NCH-1:0]    ch_match;
  logic [31:0]       ch_rd [NCH];
  logic [31:0]       rd_ch, reg_rd;
  always_comb begin
    woff     = dma_io_wadr - BASE_ADR;
    roff     = dma_io_radr - BASE_ADR;
    wr_hit   = dma_io_we && woff < WIN;
    we_vallo = wr_hit && woff == OFF_VALLO;
    we_valhi = wr_hit && woff == OFF_VALHI;
    we_cntrl = wr_hit && woff == OFF_CNTRL;
    we_intst = wr_hit && woff == OFF_INTST;
    we_inten = wr_hit && woff == OFF_INTEN;
    clr      = we_cntrl && dma_io_wdata[CNTRL_CLR];
    tick     = run_q && pcnt_q == pre_q;
    // a tick coinciding with a clear or a VALLO commit is dropped everywhere
    cnt_tick = tick && !clr && !we_vallo;
    cnt_d    = clr ? '0 : we_vallo ? {wsh_q, dma_io_wdata} : cnt_tick ? cnt_q + CNT_W'(1) : cnt_q;
    pcnt_d   = (!run_q || clr || tick) ? '0 : pcnt_q + PRE_W'(1);
    run_d    = we_cntrl ? dma_io_wdata[CNTRL_RUN] : run_q;
    pre_d    = we_cntrl ? dma_io_wdata[CNTRL_PRE +: PRE_W] : pre_q;
    wsh_d    = we_valhi ? dma_io_wdata[CNT_W-33:0] : wsh_q;
    intst_d  = (intst_q & ~(we_intst ? dma_io_wdata[NCH:0] : '0)) | {cnt_tick && &cnt_q, ch_match};
    inten_d  = we_inten ? dma_io_wdata[NCH:0] : inten_q;
    irq_d    = csr_mtie && |(intst_q & inten_q);
    rd_sel_d = dma_io_radr_en && roff < WIN;
    rsh_d    = (rd_sel_q && rd_off_q == OFF_VALLO) ? cnt_q[CNT_W-1:32] : rsh_q;
  end
  always_comb begin
    rd_ch = '0;
    for (int n = 0; n < NCH; n++)
      if ((rd_off_q & ~14'd3) == ch_off(n)) rd_ch = ch_rd[n];
    reg_rd = rd_off_q == OFF_VALLO ? cnt_q[31:0] :
             rd_off_q == OFF_VALHI ? 32'(rsh_q) :
             rd_off_q == OFF_CNTRL ? 32'({pre_q, 7'b0, run_q}) :
             rd_off_q == OFF_INTST ? 32'(intst_q) :
             rd_off_q == OFF_INTEN ? 32'(inten_q) :
             rd_off_q >= OFF_CH0   ? rd_ch : '0;
    dma_io_rdata = rd_sel_q ? reg_rd : dma_io_rdata_in;
  end
  assign frc_irq = irq_q;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    io_frc_mc_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cnt_i   (cnt_q),
      .tick_i  (cnt_tick),
      .we_i    (wr_hit && (woff & ~14'd3) == ch_off(g)),
      .wsub_i  (woff[1:0]),
      .wdata_i (dma_io_wdata),
      .rsub_i  (rd_off_q[1:0]),
      .match_o (ch_match[g]),
      .rdata_o (ch_rd[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pcnt_q   <= '0;
      pre_q    <= '0;
      run_q    <= 1'b0;
      wsh_q    <= '0;
      rsh_q    <= '0;
      intst_q  <= '0;
      inten_q  <= '0;
      irq_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_off_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      pre_q    <= pre_d;
      run_q    <= run_d;
      wsh_q    <= wsh_d;
      rsh_q    <= rsh_d;
      intst_q  <= intst_d;
      inten_q  <= inten_d;
      irq_q    <= irq_d;
      rd_sel_q <= rd_sel_d;
      rd_off_q <= roff;
    end
  end
endmodule

// File: tb/tb_io_frc_mc.sv
// tb_io_frc_mc: scoreboard bench for io_frc_mc; read expectations are queued at issue and compared on return.
module tb_io_frc_mc;
  localparam logic [13:0] BASE = 14'h3E00;
  localparam int NCH = 4;
  logic        clk = 0, rst_n = 0, we = 0, ren = 0, mtie = 0, irq;
  logic [13:0] wadr = '0, radr = '0;
  logic [31:0] wdata = '0, rdata, rin = 32'hA5A5_5A5A;
  logic        rd_pend = 0;
  int          checks = 0, fails = 0;
  logic [31:0] eq[$];
  string       tq[$];

  io_frc_mc dut (
    .clk(clk), .rst_n(rst_n), .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
    .dma_io_radr(radr), .dma_io_radr_en(ren), .dma_io_rdata_in(rin), .dma_io_rdata(rdata),
    .csr_mtie(mtie), .frc_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [13:0] a(input int off);
    return 14'(int'(BASE) + off);
  endfunction

  task automatic wr(input int off, input logic [31:0] d);
    @(negedge clk);
    we = 1; wadr = a(off); wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd(input int off, input logic [31:0] exp, input string tag);
    eq.push_back(exp);
    tq.push_back(tag);
    @(negedge clk);
    ren = 1; radr = a(off);
    @(negedge clk);
    ren = 0;
  endtask

  always @(posedge clk) rd_pend <= ren;
  always @(negedge clk)
    if (rd_pend) begin
      if (eq.size() == 0) check("sb_underflow", eq.size(), 1);
      else check(tq.pop_front(), rdata, eq.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_irq", irq, 0);
    check("idle_pass", rdata, rin);
    rd(0, 0, "rst_vallo");
    rd(2, 0, "rst_cntrl");
    rd(3, 0, "rst_intst");
    rd(10, 0, "rst_chctl0");
    // prescale 3: run for exactly 40 cycles gives 10 ticks
    wr(2, 32'h0301);
    repeat (38) @(negedge clk);
    wr(2, 32'h0300);
    rd(0, 10, "pre_vallo");
    rd(2, 32'h0300, "cntrl_rb");
    wr(0, 32'h100);
    rd(0, 32'h100, "vallo_commit");
    // channel 0 one-shot at 5
    mtie = 1;
    wr(2, 32'h2);
    wr(4, 32'h1);
    wr(8, 5);
    wr(10, 1);
    wr(2, 32'h1);
    repeat (6) @(negedge clk);
    check("irq_pre", irq, 0);
    @(negedge clk);
    check("irq_rise", irq, 1);
    rd(3, 1, "ch0_intst");
    wr(2, 0);
    rd(10, 0, "ch0_en_off");
    rd(8, 5, "ch0_cmp");
    wr(3, 1);
    @(negedge clk);
    check("irq_w1c", irq, 0);
    // channel 1 periodic 10, W1C colliding with the cnt-20 match
    wr(2, 32'h2);
    wr(12, 10);
    wr(15, 10);
    wr(14, 3);
    wr(2, 32'h1);
    repeat (13) @(negedge clk);
    wr(3, 32'h2);
    repeat (4) @(negedge clk);
    wr(3, 32'h2);
    rd(3, 32'h2, "set_beats_w1c");
    repeat (6) @(negedge clk);
    wr(2, 0);
    rd(12, 40, "ch1_cmp40");
    rd(0, 31, "ch1_cnt");
    rd(14, 3, "ch1_chctl");
    // wrap: counter 2^40-2, channel 2 periodic reload across the wrap
    wr(3, 32'h1F);
    wr(1, 32'hFF);
    wr(0, 32'hFFFF_FFFE);
    wr(17, 32'hFF);
    wr(16, 32'hFFFF_FFFF);
    wr(19, 3);
    wr(18, 3);
    wr(2, 32'h1);
    wr(2, 0);
    rd(0, 0, "wrap_lo");
    rd(1, 0, "wrap_hi");
    rd(3, 32'h14, "wrap_intst");
    rd(16, 2, "ch2_cmplo");
    rd(17, 0, "ch2_cmphi");
    // atomic read across a carry
    wr(1, 0);
    wr(0, 32'hFFFF_FFFF);
    wr(2, 32'hFF01);
    rd(0, 32'hFFFF_FFFF, "atom_lo");
    repeat (300) @(negedge clk);
    rd(1, 0, "atom_hi_shadow");
    rd(0, 0, "atom_lo2");
    rd(1, 1, "atom_hi2");
    // clear while a tick is pending
    wr(2, 0);
    wr(2, 32'h1);
    repeat (3) @(negedge clk);
    wr(2, 32'h2);
    rd(0, 0, "clr_lo");
    rd(1, 0, "clr_hi");
    // decode edges
    rd(8 + 4 * NCH, rin, "out_above");
    rd(-1, rin, "out_below");
    rd(5, 0, "reserved");
    // async reset mid shadow sequence
    wr(1, 32'h55);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    wr(0, 7);
    rd(0, 7, "rst_lo");
    rd(1, 0, "rst_hi");
    rd(3, 0, "rst_intst2");
    check("rst_irq2", irq, 0);
    repeat (4) @(negedge clk);
    check("sb_drain", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
